// File: rtl/alu_cmd_sequencer_if.sv
// Command and result handshake bundle for alu_cmd_sequencer.
// master: the side that issues commands and consumes results.
// slave:  the sequencer itself.
interface alu_cmd_sequencer_if #(
    parameter int WIDTH = 8,
    parameter int MODEW = 4
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [WIDTH-1:0] cmd_a;
    logic [WIDTH-1:0] cmd_b;
    logic [MODEW-1:0] cmd_mode;

    logic             res_valid;
    logic             res_ready;
    logic [WIDTH-1:0] res_data;
    logic [MODEW-1:0] res_mode;

    modport master (
        output cmd_valid, cmd_a, cmd_b, cmd_mode, res_ready,
        input  cmd_ready, res_valid, res_data, res_mode
    );

    modport slave (
        input  cmd_valid, cmd_a, cmd_b, cmd_mode, res_ready,
        output cmd_ready, res_valid, res_data, res_mode
    );
endinterface

// File: rtl/alu_cmd_sequencer.sv
// Command FIFO and issue FSM wrapped around a combinational ALU.
// Commands are queued, issued one at a time on alu_a/b/mode, given one
// full cycle to settle, and the ALU output is returned on a registered
// valid/ready result port.
//
//   state | meaning
//   IDLE  | no command in the ALU; pops the FIFO head when one is queued
//   EXEC  | ALU inputs settled for a full cycle; result captured at the edge
//   HOLD  | result presented on res_*; returns to IDLE on res_ready
module alu_cmd_sequencer #(
    parameter int WIDTH = 8,
    parameter int MODEW = 4,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    alu_cmd_sequencer_if.slave     bus,
    output logic [WIDTH-1:0]       alu_a,
    output logic [WIDTH-1:0]       alu_b,
    output logic [MODEW-1:0]       alu_mode,
    input  logic [WIDTH-1:0]       alu_out,
    output logic [$clog2(DEPTH):0] level
);
    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_LEVEL = (PW + 1)'(DEPTH);
    localparam logic [PW:0]   CNT_ONE    = (PW + 1)'(1);
    localparam logic [PW-1:0] PTR_ONE    = PW'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        HOLD = 2'd2
    } state_t;

    state_t state, state_nxt;

    logic [WIDTH-1:0] mem_a    [DEPTH];
    logic [WIDTH-1:0] mem_b    [DEPTH];
    logic [MODEW-1:0] mem_mode [DEPTH];

    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          full, empty, push, pop;
    logic          res_load, res_clear;

    logic             res_valid_q;
    logic [WIDTH-1:0] res_data_q;
    logic [MODEW-1:0] res_mode_q;

    // Ready depends only on registered occupancy, so a same-cycle pop
    // never opens a slot for a push.
    assign full          = (count == FULL_LEVEL);
    assign empty         = (count == '0);
    assign push          = bus.cmd_valid && !full;
    assign bus.cmd_ready = !full;
    assign level         = count;

    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = res_data_q;
    assign bus.res_mode  = res_mode_q;

    // FIFO storage; entries are only meaningful between rd_ptr and wr_ptr.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_a[wr_ptr]    <= bus.cmd_a;
            mem_b[wr_ptr]    <= bus.cmd_b;
            mem_mode[wr_ptr] <= bus.cmd_mode;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state and per-state strobes.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        res_load  = 1'b0;
        res_clear = 1'b0;
        case (state)
            IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                res_load  = 1'b1;
                state_nxt = HOLD;
            end
            HOLD: begin
                if (bus.res_ready) begin
                    res_clear = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // ALU operand registers; they change only on a pop so the ALU stays
    // quiet while a result is held.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a    <= '0;
            alu_b    <= '0;
            alu_mode <= '0;
        end else if (pop) begin
            alu_a    <= mem_a[rd_ptr];
            alu_b    <= mem_b[rd_ptr];
            alu_mode <= mem_mode[rd_ptr];
        end
    end

    // Result capture after the settle cycle, held until consumed.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            res_valid_q <= 1'b0;
            res_data_q  <= '0;
            res_mode_q  <= '0;
        end else if (res_load) begin
            res_valid_q <= 1'b1;
            res_data_q  <= alu_out;
            res_mode_q  <= alu_mode;
        end else if (res_clear) begin
            res_valid_q <= 1'b0;
        end
    end
endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Self-checking bench for alu_cmd_sequencer driven by an adder stub ALU.
module tb_alu_cmd_sequencer;
    localparam int WIDTH = 8;
    localparam int MODEW = 4;
    localparam int DEPTH = 4;

    typedef struct {
        logic [WIDTH-1:0] data;
        logic [MODEW-1:0] mode;
    } res_t;

    logic                   clk = 1'b0;
    logic                   rst_n;
    logic [WIDTH-1:0]       alu_a, alu_b, alu_out;
    logic [MODEW-1:0]       alu_mode;
    logic [$clog2(DEPTH):0] level;

    int   n_checks = 0;
    int   n_fail   = 0;
    res_t exp_q[$];

    alu_cmd_sequencer_if #(.WIDTH(WIDTH), .MODEW(MODEW)) bus ();

    alu_cmd_sequencer #(.WIDTH(WIDTH), .MODEW(MODEW), .DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .alu_a    (alu_a),
        .alu_b    (alu_b),
        .alu_mode (alu_mode),
        .alu_out  (alu_out),
        .level    (level)
    );

    always #5 clk = ~clk;

    // Stub ALU: out = A + B truncated to 8 bits.
    assign alu_out = alu_a + alu_b;

    // Reference: result is the sum of the operands modulo 2**WIDTH, tagged with its opcode.
    function automatic res_t model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                   input logic [MODEW-1:0] m);
        res_t r;
        int   sum;
        sum    = int'(a) + int'(b);
        r.data = WIDTH'(sum % (1 << WIDTH));
        r.mode = m;
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offers one command and returns once it has been accepted (or gives up).
    task automatic push_cmd(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                            input logic [MODEW-1:0] m, output int waited);
        logic rdy;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        bus.cmd_mode  = m;
        bus.cmd_valid = 1'b1;
        waited = 0;
        while (waited < 50) begin
            rdy = bus.cmd_ready;
            tick();
            if (rdy) break;
            waited++;
        end
        bus.cmd_valid = 1'b0;
    endtask

    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.cmd_mode  = '0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;
        tick();
        tick();
        n_checks++; if (bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_cmd_ready: got %b expected 1", bus.cmd_ready); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL reset_res_valid: got %b expected 0", bus.res_valid); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level); end
        n_checks++; if (bus.res_data !== '0 || bus.res_mode !== '0) begin n_fail++; $display("FAIL reset_res: got data %0h mode %0h expected 0/0", bus.res_data, bus.res_mode); end
        n_checks++; if (alu_a !== '0 || alu_b !== '0 || alu_mode !== '0) begin n_fail++; $display("FAIL reset_alu: got %0h %0h %0h expected 0 0 0", alu_a, alu_b, alu_mode); end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_op();
        int waited;
        bus.res_ready = 1'b1;
        push_cmd(8'h0A, 8'h02, 4'h1, waited);
        n_checks++; if (waited != 0) begin n_fail++; $display("FAIL single_accept: waited %0d cycles expected 0", waited); end
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early0: res_valid %b expected 0", bus.res_valid); end
        tick();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL single_early1: res_valid %b expected 0", bus.res_valid); end
        n_checks++; if (alu_a !== 8'h0A || alu_b !== 8'h02 || alu_mode !== 4'h1) begin n_fail++; $display("FAIL single_alu_in: got %0h %0h %0h expected a 2 1", alu_a, alu_b, alu_mode); end
        tick();
        n_checks++; if (bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL single_valid: res_valid %b expected 1", bus.res_valid); end
        n_checks++; if (bus.res_data !== 8'h0C || bus.res_mode !== 4'h1) begin n_fail++; $display("FAIL single_result: got %0h/%0h expected c/1", bus.res_data, bus.res_mode); end
        tick();
        n_checks++; if (bus.res_valid !== 1'b0 || level !== '0) begin n_fail++; $display("FAIL single_done: res_valid %b level %0d expected 0/0", bus.res_valid, level); end
    endtask

    task automatic test_fill();
        logic [WIDTH-1:0] fa [6];
        logic [WIDTH-1:0] fb [6];
        logic [MODEW-1:0] fm [6];
        int   waited, late, rdy_seen, got, cyc;
        logic acc, hs;
        res_t e;
        exp_q.delete();
        for (int i = 0; i < 6; i++) begin
            fa[i] = WIDTH'($urandom);
            fb[i] = WIDTH'($urandom);
            fm[i] = MODEW'($urandom);
            exp_q.push_back(model(fa[i], fb[i], fm[i]));
        end
        bus.res_ready = 1'b0;
        late = 0;
        for (int i = 0; i < 5; i++) begin
            push_cmd(fa[i], fb[i], fm[i], waited);
            late += waited;
        end
        n_checks++; if (late != 0) begin n_fail++; $display("FAIL fill_streak: %0d stall cycles expected 0", late); end
        n_checks++; if (level !== 3'd4) begin n_fail++; $display("FAIL fill_level: got %0d expected 4", level); end
        n_checks++; if (bus.cmd_ready !== 1'b0) begin n_fail++; $display("FAIL fill_ready: got %b expected 0", bus.cmd_ready); end
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== exp_q[0].data) begin n_fail++; $display("FAIL fill_hold: valid %b data %0h expected 1/%0h", bus.res_valid, bus.res_data, exp_q[0].data); end
        bus.cmd_a     = fa[5];
        bus.cmd_b     = fb[5];
        bus.cmd_mode  = fm[5];
        bus.cmd_valid = 1'b1;
        rdy_seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (bus.cmd_ready) rdy_seen++;
            tick();
        end
        n_checks++; if (rdy_seen != 0 || level !== 3'd4) begin n_fail++; $display("FAIL fill_blocked: ready cycles %0d level %0d expected 0/4", rdy_seen, level); end
        bus.res_ready = 1'b1;
        got = 0;
        cyc = 0;
        while (got < 6 && cyc < 100) begin
            acc = bus.cmd_valid && bus.cmd_ready;
            hs  = bus.res_valid && bus.res_ready;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL fill_extra: unexpected result %0h/%0h", bus.res_data, bus.res_mode);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.res_data !== e.data || bus.res_mode !== e.mode) begin
                        n_fail++; $display("FAIL fill_result%0d: got %0h/%0h expected %0h/%0h", got, bus.res_data, bus.res_mode, e.data, e.mode);
                    end
                end
                got++;
            end
            tick();
            cyc++;
            if (acc) bus.cmd_valid = 1'b0;
        end
        n_checks++; if (got != 6 || level !== '0) begin n_fail++; $display("FAIL fill_drain: results %0d level %0d expected 6/0", got, level); end
    endtask

    task automatic test_backpressure();
        logic [WIDTH-1:0] a, b;
        logic [MODEW-1:0] m;
        res_t e;
        int   waited;
        a = WIDTH'($urandom);
        b = WIDTH'($urandom);
        m = MODEW'($urandom);
        e = model(a, b, m);
        bus.res_ready = 1'b0;
        push_cmd(a, b, m, waited);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            n_checks++;
            if (bus.res_valid !== 1'b1 || bus.res_data !== e.data || bus.res_mode !== e.mode) begin
                n_fail++; $display("FAIL bp_result%0d: got %b %0h/%0h expected 1 %0h/%0h", i, bus.res_valid, bus.res_data, bus.res_mode, e.data, e.mode);
            end
            n_checks++;
            if (alu_a !== a || alu_b !== b || alu_mode !== m) begin
                n_fail++; $display("FAIL bp_alu%0d: got %0h %0h %0h expected %0h %0h %0h", i, alu_a, alu_b, alu_mode, a, b, m);
            end
            tick();
        end
        bus.res_ready = 1'b1;
        tick();
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release: res_valid %b expected 0", bus.res_valid); end
    endtask

    task automatic test_ordering();
        int   sent, got, cyc;
        logic acc, hs;
        res_t e;
        exp_q.delete();
        sent = 0;
        got  = 0;
        cyc  = 0;
        bus.res_ready = 1'b1;
        bus.cmd_a     = 8'hF6;
        bus.cmd_b     = 8'h0A;
        bus.cmd_mode  = 4'h1;
        bus.cmd_valid = 1'b1;
        while (got < 15 && cyc < 300) begin
            acc = bus.cmd_valid && bus.cmd_ready;
            hs  = bus.res_valid && bus.res_ready;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL order_extra: unexpected result %0h/%0h", bus.res_data, bus.res_mode);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.res_data !== e.data || bus.res_mode !== e.mode) begin
                        n_fail++; $display("FAIL order_result%0d: got %0h/%0h expected %0h/%0h", got, bus.res_data, bus.res_mode, e.data, e.mode);
                    end
                end
                got++;
            end
            if (acc) begin
                exp_q.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_mode));
                sent++;
            end
            tick();
            cyc++;
            if (acc) begin
                if (sent < 15) bus.cmd_mode = MODEW'(sent + 1);
                else           bus.cmd_valid = 1'b0;
            end
        end
        n_checks++; if (got != 15) begin n_fail++; $display("FAIL order_count: got %0d results expected 15", got); end
        n_checks++; if (level !== '0) begin n_fail++; $display("FAIL order_level: got %0d expected 0", level); end
    endtask

    // Keeps two entries queued and pushes exactly on pop cycles so the
    // pointers lap the FIFO several times with simultaneous push and pop.
    task automatic test_wrap();
        int   sent, got, cyc, both, pop_inf, lvl_before, waited, total;
        logic acc, hs, fire;
        logic [WIDTH-1:0] a, b;
        logic [MODEW-1:0] m;
        res_t e;
        total = 15;
        exp_q.delete();
        sent = 0; got = 0; cyc = 0; both = 0; fire = 1'b0;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            a = WIDTH'($urandom); b = WIDTH'($urandom); m = MODEW'($urandom);
            push_cmd(a, b, m, waited);
            exp_q.push_back(model(a, b, m));
            sent++;
        end
        while (got < total && cyc < 600) begin
            bus.res_ready = ($urandom_range(3) != 0);
            if (fire && sent < total) begin
                bus.cmd_a     = WIDTH'($urandom);
                bus.cmd_b     = WIDTH'($urandom);
                bus.cmd_mode  = MODEW'($urandom);
                bus.cmd_valid = 1'b1;
            end
            fire = 1'b0;
            acc = bus.cmd_valid && bus.cmd_ready;
            hs  = bus.res_valid && bus.res_ready;
            if (hs) begin
                n_checks++;
                if (exp_q.size() == 0) begin
                    n_fail++; $display("FAIL wrap_extra: unexpected result %0h/%0h", bus.res_data, bus.res_mode);
                end else begin
                    e = exp_q.pop_front();
                    if (bus.res_data !== e.data || bus.res_mode !== e.mode) begin
                        n_fail++; $display("FAIL wrap_result%0d: got %0h/%0h expected %0h/%0h", got, bus.res_data, bus.res_mode, e.data, e.mode);
                    end
                end
                got++;
                fire = 1'b1;
            end
            if (acc) begin
                exp_q.push_back(model(bus.cmd_a, bus.cmd_b, bus.cmd_mode));
                sent++;
            end
            lvl_before = int'(level);
            tick();
            cyc++;
            if (acc) bus.cmd_valid = 1'b0;
            pop_inf = lvl_before + int'(acc) - int'(level);
            n_checks++;
            if (pop_inf < 0 || pop_inf > 1) begin
                n_fail++; $display("FAIL wrap_level_step: level %0d -> %0d with push %b", lvl_before, level, acc);
            end
            if (acc && pop_inf == 1) both++;
        end
        n_checks++; if (got != total) begin n_fail++; $display("FAIL wrap_count: got %0d results expected %0d", got, total); end
        n_checks++; if (both <= 2 * DEPTH) begin n_fail++; $display("FAIL wrap_overlap: %0d push+pop cycles expected more than %0d", both, 2 * DEPTH); end
        n_checks++; if (level !== '0 || exp_q.size() != 0) begin n_fail++; $display("FAIL wrap_empty: level %0d pending %0d expected 0/0", level, exp_q.size()); end
    endtask

    task automatic test_reset_mid_op();
        int waited, stale;
        bus.res_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            push_cmd(WIDTH'($urandom), WIDTH'($urandom), MODEW'($urandom), waited);
        end
        n_checks++; if (level !== 3'd3 || bus.res_valid !== 1'b1) begin n_fail++; $display("FAIL rst_pre: level %0d valid %b expected 3/1", level, bus.res_valid); end
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        n_checks++; if (bus.res_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b expected 0", bus.res_valid); end
        n_checks++; if (level !== '0 || bus.cmd_ready !== 1'b1) begin n_fail++; $display("FAIL rst_fifo: level %0d ready %b expected 0/1", level, bus.cmd_ready); end
        n_checks++; if (bus.res_data !== '0 || alu_a !== '0) begin n_fail++; $display("FAIL rst_regs: data %0h alu_a %0h expected 0/0", bus.res_data, alu_a); end
        bus.res_ready = 1'b1;
        stale = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (bus.res_valid) stale++;
        end
        n_checks++; if (stale != 0) begin n_fail++; $display("FAIL rst_stale: %0d cycles with res_valid expected 0", stale); end
        push_cmd(8'h03, 8'h04, 4'h2, waited);
        tick();
        tick();
        n_checks++; if (bus.res_valid !== 1'b1 || bus.res_data !== 8'h07 || bus.res_mode !== 4'h2) begin n_fail++; $display("FAIL rst_recover: got %b %0h/%0h expected 1 7/2", bus.res_valid, bus.res_data, bus.res_mode); end
        tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single_op();
        test_fill();
        test_backpressure();
        test_ordering();
        test_wrap();
        test_reset_mid_op();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
